// File: rtl/mips_arb_pkg.sv
// rtl/mips_arb_pkg.sv - shared state, requester and grant definitions for the MIPS memory arbiter
package mips_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IF   = 2'd1,
        REQ_DM   = 2'd2,
        REQ_LD   = 2'd3
    } req_id_e;

    localparam int STATS_W  = 16;
    localparam int STARVE_W = 4;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_IF = 0;
    localparam int GNT_DM = 1;
    localparam int GNT_LD = 2;

    function automatic req_id_e grant_to_id(input logic [2:0] gnt);
        req_id_e id;
        id = REQ_NONE;
        if (gnt[GNT_LD]) begin
            id = REQ_LD;
        end else if (gnt[GNT_DM]) begin
            id = REQ_DM;
        end else if (gnt[GNT_IF]) begin
            id = REQ_IF;
        end
        return id;
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - requester and memory-side signal bundle of the MIPS memory arbiter
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rsp_valid;

    logic              dm_valid;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic              dm_rsp_valid;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ready;
    logic              ld_rsp_valid;

    logic [DATA_W-1:0] rsp_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  if_valid, if_addr,
        input  dm_valid, dm_we, dm_addr, dm_wdata,
        input  ld_valid, ld_addr, ld_wdata,
        input  mem_rdata,
        output if_ready, if_rsp_valid,
        output dm_ready, dm_rsp_valid,
        output ld_ready, ld_rsp_valid,
        output rsp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters and memory view
    modport master (
        output if_valid, if_addr,
        output dm_valid, dm_we, dm_addr, dm_wdata,
        output ld_valid, ld_addr, ld_wdata,
        output mem_rdata,
        input  if_ready, if_rsp_valid,
        input  dm_ready, dm_rsp_valid,
        input  ld_ready, ld_rsp_valid,
        input  rsp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mips_arb_prio.sv
// rtl/mips_arb_prio.sv - combinational winner select: LD > starved IF > DM > IF, one-hot grant
module mips_arb_prio
    import mips_arb_pkg::*;
(
    input  logic       arb_en,
    input  logic       ld_valid,
    input  logic       dm_valid,
    input  logic       if_elig,
    input  logic       starved,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (arb_en) begin
            if (ld_valid) begin
                gnt[GNT_LD] = 1'b1;
            end else if (starved && if_elig) begin
                gnt[GNT_IF] = 1'b1;
            end else if (dm_valid) begin
                gnt[GNT_DM] = 1'b1;
            end else if (if_elig) begin
                gnt[GNT_IF] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - single-port memory arbiter for IF/DM/LD; MIPS_ARB_STATS_EN adds grant/conflict counters
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               halted,
    mips_mem_arbiter_if.slave  bus
`ifdef MIPS_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_if_cnt,
    output logic [STATS_W-1:0] stat_dm_cnt,
    output logic [STATS_W-1:0] stat_conflict_cnt
`endif
);

    arb_state_e         state_q, state_d;
    req_id_e            owner_q, owner_d;
    logic               owner_rd_q, owner_rd_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

    logic               arb_pt;
    logic               if_elig;
    logic               starved;
    logic [2:0]         gnt;
    req_id_e            win;

    // Reset also masks the readies so every output is 0 while rst_n is low
    assign arb_pt  = rst_n && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    assign if_elig = bus.if_valid && !halted;
    assign starved = (starve_q >= STARVE_W'(STARVE_LIMIT));
    assign win     = grant_to_id(gnt);

    mips_arb_prio u_prio (
        .arb_en   (arb_pt),
        .ld_valid (bus.ld_valid),
        .dm_valid (bus.dm_valid),
        .if_elig  (if_elig),
        .starved  (starved),
        .gnt      (gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_rd_d  = owner_rd_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;

        case (state_q)
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_IDLE, ST_RESP: begin
                if (win != REQ_NONE) begin
                    state_d  = ST_ACCESS;
                    owner_d  = win;
                    mem_en_d = 1'b1;
                    case (win)
                        REQ_LD: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = bus.ld_addr;
                            mem_wdata_d = bus.ld_wdata;
                            owner_rd_d  = 1'b0;
                        end
                        REQ_DM: begin
                            mem_we_d    = bus.dm_we;
                            mem_addr_d  = bus.dm_addr;
                            mem_wdata_d = bus.dm_wdata;
                            owner_rd_d  = !bus.dm_we;
                        end
                        default: begin
                            mem_we_d    = 1'b0;
                            mem_addr_d  = bus.if_addr;
                            mem_wdata_d = '0;
                            owner_rd_d  = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                    owner_d = REQ_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = REQ_NONE;
            end
        endcase

        // Starvation only accumulates while IF keeps asking and keeps losing
        if (!if_elig) begin
            starve_d = '0;
        end else if (arb_pt) begin
            if (gnt[GNT_IF]) begin
                starve_d = '0;
            end else if (starve_q != {STARVE_W{1'b1}}) begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_NONE;
            owner_rd_q  <= 1'b0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_rd_q  <= owner_rd_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    logic in_resp;
    assign in_resp = (state_q == ST_RESP);

    assign bus.if_ready     = gnt[GNT_IF];
    assign bus.dm_ready     = gnt[GNT_DM];
    assign bus.ld_ready     = gnt[GNT_LD];
    assign bus.if_rsp_valid = in_resp && (owner_q == REQ_IF);
    assign bus.dm_rsp_valid = in_resp && (owner_q == REQ_DM);
    assign bus.ld_rsp_valid = in_resp && (owner_q == REQ_LD);
    assign bus.rsp_rdata    = (in_resp && owner_rd_q) ? bus.mem_rdata : '0;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;

`ifdef MIPS_ARB_STATS_EN
    logic [STATS_W-1:0] stat_if_q, stat_if_d;
    logic [STATS_W-1:0] stat_dm_q, stat_dm_d;
    logic [STATS_W-1:0] stat_cf_q, stat_cf_d;
    logic [1:0]         n_elig;

    always_comb begin
        stat_if_d = stat_if_q;
        stat_dm_d = stat_dm_q;
        stat_cf_d = stat_cf_q;
        n_elig    = {1'b0, bus.ld_valid} + {1'b0, bus.dm_valid} + {1'b0, if_elig};
        if (gnt[GNT_IF]) begin
            stat_if_d = stat_if_q + STATS_W'(1);
        end
        if (gnt[GNT_DM]) begin
            stat_dm_d = stat_dm_q + STATS_W'(1);
        end
        if (arb_pt && (n_elig >= 2'd2)) begin
            stat_cf_d = stat_cf_q + STATS_W'(1);
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_q <= '0;
            stat_dm_q <= '0;
            stat_cf_q <= '0;
        end else begin
            stat_if_q <= stat_if_d;
            stat_dm_q <= stat_dm_d;
            stat_cf_q <= stat_cf_d;
        end
    end

    assign stat_if_cnt       = stat_if_q;
    assign stat_dm_cnt       = stat_dm_q;
    assign stat_conflict_cnt = stat_cf_q;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - randomized bench for mips_mem_arbiter with a cycle-count based reference model
module tb_mips_mem_arbiter;
    import mips_arb_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic clk1;
    logic rst_n;
    logic halted;

    mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MIPS_ARB_STATS_EN
    logic [15:0] stat_if_cnt, stat_dm_cnt, stat_conflict_cnt;
`endif

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .halted (halted),
        .bus    (bus)
`ifdef MIPS_ARB_STATS_EN
        ,
        .stat_if_cnt       (stat_if_cnt),
        .stat_dm_cnt       (stat_dm_cnt),
        .stat_conflict_cnt (stat_conflict_cnt)
`endif
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // Memory device attached to the arbiter: one-cycle synchronous read
    logic [DW-1:0] tmem [0:(1<<AW)-1] = '{default: '0};
    always @(posedge clk1) begin
        if (bus.mem_en) begin
            if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= tmem[bus.mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: "age" = cycles since the last accept (3 = nothing in flight)
    logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
    int            age = 3;
    int            starve = 0;
    int            cur_owner = 0;
    logic          cur_we = 1'b0;
    logic          cur_rd = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    int            m_if = 0, m_dm = 0, m_cf = 0;
    byte           glog[$];
    int            obs_ld_rsp = 0;
    int            obs_if_rdy = 0;

    task automatic model_step();
        int            win;
        int            n_el;
        logic          free, ifel;
        logic          e_ir, e_dr, e_lr, e_irv, e_drv, e_lrv, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        win = 0; free = 1'b0;
        {e_ir, e_dr, e_lr, e_irv, e_drv, e_lrv, e_en, e_we} = '0;
        e_addr = '0; e_wd = '0; e_rd = '0;
        ifel = bus.if_valid && !halted;
        n_el = int'(bus.ld_valid) + int'(bus.dm_valid) + int'(ifel);
        if (rst_n) begin
            free = (age >= 2);
            if (free) begin
                if (bus.ld_valid) win = 3;
                else if (starve >= LIMIT && ifel) win = 1;
                else if (bus.dm_valid) win = 2;
                else if (ifel) win = 1;
            end
            e_ir = (win == 1); e_dr = (win == 2); e_lr = (win == 3);
            if (age == 1) begin
                e_en = 1'b1; e_we = cur_we; e_addr = cur_addr; e_wd = cur_wdata;
            end
            if (age == 2) begin
                e_irv = (cur_owner == 1); e_drv = (cur_owner == 2); e_lrv = (cur_owner == 3);
                e_rd  = cur_rd ? ref_mem[cur_addr] : '0;
            end
        end
        chk("if_ready", 32'(bus.if_ready), 32'(e_ir));
        chk("dm_ready", 32'(bus.dm_ready), 32'(e_dr));
        chk("ld_ready", 32'(bus.ld_ready), 32'(e_lr));
        chk("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(e_irv));
        chk("dm_rsp_valid", 32'(bus.dm_rsp_valid), 32'(e_drv));
        chk("ld_rsp_valid", 32'(bus.ld_rsp_valid), 32'(e_lrv));
        chk("rsp_rdata", bus.rsp_rdata, e_rd);
        chk("mem_en", 32'(bus.mem_en), 32'(e_en));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (!(e_en && !e_we)) chk("mem_wdata", bus.mem_wdata, e_wd);
`ifdef MIPS_ARB_STATS_EN
        chk("stat_if_cnt", 32'(stat_if_cnt), 32'(m_if[15:0]));
        chk("stat_dm_cnt", 32'(stat_dm_cnt), 32'(m_dm[15:0]));
        chk("stat_conflict_cnt", 32'(stat_conflict_cnt), 32'(m_cf[15:0]));
`endif
        if (bus.if_ready) glog.push_back("I");
        if (bus.dm_ready) glog.push_back("D");
        if (bus.ld_ready) glog.push_back("L");
        obs_ld_rsp += int'(bus.ld_rsp_valid);
        obs_if_rdy += int'(bus.if_ready);

        if (!rst_n) begin
            age = 3; starve = 0; m_if = 0; m_dm = 0; m_cf = 0;
        end else begin
            if (age == 1 && cur_we) ref_mem[cur_addr] = cur_wdata;
            if (free && n_el >= 2) m_cf++;
            if (win == 1) m_if++;
            if (win == 2) m_dm++;
            if (!ifel) starve = 0;
            else if (free) starve = (win == 1) ? 0 : ((starve < 15) ? starve + 1 : 15);
            if (win != 0) begin
                cur_owner = win;
                case (win)
                    1: begin cur_we = 1'b0; cur_rd = 1'b1; cur_addr = bus.if_addr; cur_wdata = '0; end
                    2: begin cur_we = bus.dm_we; cur_rd = !bus.dm_we; cur_addr = bus.dm_addr; cur_wdata = bus.dm_wdata; end
                    default: begin cur_we = 1'b1; cur_rd = 1'b0; cur_addr = bus.ld_addr; cur_wdata = bus.ld_wdata; end
                endcase
                age = 1;
            end else if (age < 3) begin
                age++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk1);
            model_step();
        end
    end

    task automatic wait_rdy(input int who);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk1); #1;
            got = (who == 1) ? bus.if_ready : (who == 2) ? bus.dm_ready : bus.ld_ready;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL wait_rdy requester=%0d: ready not seen, required 1", who);
        end
    endtask

    task automatic step_in();
        @(posedge clk1); #1;
    endtask

    task automatic sample();
        @(negedge clk1); #1;
    endtask

    task automatic ld_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_wdata = d;
        wait_rdy(3);
        step_in();
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        string exp_s;
        rst_n = 1'b0; halted = 1'b0;
        bus.if_valid = 0; bus.if_addr = '0;
        bus.dm_valid = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        repeat (3) step_in();
        rst_n = 1'b1;

        // Reset during a DM load's ACCESS cycle discards it
        bus.dm_valid = 1; bus.dm_we = 0; bus.dm_addr = 10'd5;
        wait_rdy(2);
        step_in();
        bus.dm_valid = 0; rst_n = 1'b0;
        sample();
        chk("t1_mem_en_after_reset", 32'(bus.mem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_no_dm_rsp", 32'(bus.dm_rsp_valid), 32'd0);
            if (i < 2) sample();
        end
        step_in();
        rst_n = 1'b1;
        bus.if_valid = 1; bus.if_addr = 10'd3;
        wait_rdy(1);
        chk("t1_if_ready", 32'(bus.if_ready), 32'd1);
        step_in();
        bus.if_valid = 0;
        sample();
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'd3);
        sample();
        chk("t1_if_rsp", 32'(bus.if_rsp_valid), 32'd1);
        chk("t1_dm_rsp", 32'(bus.dm_rsp_valid), 32'd0);

        // Loader fills memory while halted; IF must never be granted
        step_in();
        halted = 1; bus.if_valid = 1; bus.if_addr = 10'd0;
        obs_ld_rsp = 0; obs_if_rdy = 0;
        ld_write(10'd0, 32'h2801000a);
        ld_write(10'd1, 32'h28020014);
        repeat (4) sample();
        chk("t2_ld_rsp_count", 32'(obs_ld_rsp), 32'd2);
        chk("t2_if_ready_count", 32'(obs_if_rdy), 32'd0);

        // Release HALTED and fetch word 1
        step_in();
        halted = 0; bus.if_addr = 10'd1;
        wait_rdy(1);
        step_in();
        bus.if_valid = 0;
        sample();
        chk("t3_mem_en", 32'(bus.mem_en), 32'd1);
        chk("t3_mem_addr", 32'(bus.mem_addr), 32'd1);
        sample();
        chk("t3_if_rsp", 32'(bus.if_rsp_valid), 32'd1);
        chk("t3_rdata", bus.rsp_rdata, 32'h28020014);

        // IF and DM both continuously valid: IF wins every 5th grant
        step_in();
        rst_n = 1'b0;
        repeat (2) step_in();
        rst_n = 1'b1;
        bus.if_valid = 1; bus.if_addr = 10'd2;
        bus.dm_valid = 1; bus.dm_we = 0; bus.dm_addr = 10'd0;
        glog.delete();
        for (int i = 0; i < 60 && glog.size() < 10; i++) sample();
        exp_s = "DDDDIDDDDI";
        chk("t4_grant_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            chk($sformatf("t4_grant_%0d", i), 32'(glog[i]), 32'(exp_s[i]));
        sample();
`ifdef MIPS_ARB_STATS_EN
        chk("t6_stat_dm", 32'(stat_dm_cnt), 32'd8);
        chk("t6_stat_if", 32'(stat_if_cnt), 32'd2);
        chk("t6_stat_conflict", 32'(stat_conflict_cnt), 32'd10);
`endif
        step_in();
        bus.if_valid = 0; bus.dm_valid = 0;
        repeat (3) step_in();

        // Back-to-back store then load at word 8
        bus.dm_valid = 1; bus.dm_we = 1; bus.dm_addr = 10'd8; bus.dm_wdata = 32'hfc000000;
        wait_rdy(2);
        step_in();
        bus.dm_we = 0; bus.dm_wdata = '0;
        wait_rdy(2);
        chk("t5_store_ack_with_load_accept", 32'(bus.dm_rsp_valid), 32'd1);
        step_in();
        bus.dm_valid = 0;
        sample();
        sample();
        chk("t5_load_rsp", 32'(bus.dm_rsp_valid), 32'd1);
        chk("t5_load_rdata", bus.rsp_rdata, 32'hfc000000);

        // Randomized traffic, including dropped valids, HALTED toggling and resets
        for (int c = 0; c < 3000; c++) begin
            step_in();
            rst_n        = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0) halted = ~halted;
            bus.ld_valid = ($urandom_range(0, 9) == 0);
            bus.ld_addr  = AW'($urandom_range(0, 15));
            bus.ld_wdata = $urandom;
            bus.dm_valid = ($urandom_range(0, 1) == 0);
            bus.dm_we    = ($urandom_range(0, 2) == 0);
            bus.dm_addr  = AW'($urandom_range(0, 15));
            bus.dm_wdata = $urandom;
            bus.if_valid = ($urandom_range(0, 4) < 3);
            bus.if_addr  = AW'($urandom_range(0, 15));
        end
        step_in();
        rst_n = 1'b1; halted = 0;
        bus.ld_valid = 0; bus.dm_valid = 0; bus.if_valid = 0;
        repeat (4) step_in();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
